// File: rtl/av_pkg.sv
// Shared constants and types for the video/audio stream buffer.
// Frame geometry, colour width, audio mid-scale and the stream parser state.
package av_pkg;

    localparam int LINE_PIXELS  = 640;
    localparam int ACTIVE_LINES = 480;
    localparam int TOTAL_LINES  = 525;
    localparam int COLOUR_W     = 6;

    localparam logic [7:0] AUDIO_MID = 8'h80;

    typedef enum logic [0:0] {
        PIX = 1'b0,
        AUD = 1'b1
    } parse_state_t;

    // Upper stream bits of a pixel byte carry no colour information.
    function automatic logic [COLOUR_W-1:0] pixel_colour(input logic [7:0] b);
        return b[COLOUR_W-1:0];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Count-based synchronous FIFO for the pixel colour queue.
// Push is ignored when full and pop is ignored when empty.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 6
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == {CW{1'b0}});
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_head  = r_mem[r_rd_ptr];

    // Storage array; contents are meaningless while the count says empty.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers and occupancy count.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/av_stream_buffer.sv
// Demultiplexes the interleaved pixel/audio byte stream: pixels are queued for
// the VGA pixel pipeline, one audio sample per line is released at hsync fall.
module av_stream_buffer
    import av_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int LINE_PIXELS  = av_pkg::LINE_PIXELS,
    parameter int ACTIVE_LINES = av_pkg::ACTIVE_LINES,
    parameter int TOTAL_LINES  = av_pkg::TOTAL_LINES
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [7:0]          i_in_data,
    input  logic                i_in_valid,
    output logic                o_in_ready,
    input  logic                i_pixel_req,
    input  logic                i_hsync,
    output logic [COLOUR_W-1:0] o_rgb,
    output logic [7:0]          o_audio_sample,
    output logic                o_audio_update,
    output logic                o_pix_underrun,
    output logic                o_aud_underrun
);

    localparam int PW = (LINE_PIXELS > 1) ? $clog2(LINE_PIXELS) : 1;
    localparam int LW = (TOTAL_LINES > 1) ? $clog2(TOTAL_LINES) : 1;

    parse_state_t        r_state;
    logic [PW-1:0]       r_pix_cnt;
    logic [LW-1:0]       r_line_cnt;
    logic                r_run;
    logic [7:0]          r_hold;
    logic                r_hold_valid;
    logic                r_hsync_d;
    logic [COLOUR_W-1:0] r_rgb;
    logic [7:0]          r_audio_sample;
    logic                r_audio_update;
    logic                r_pix_underrun;
    logic                r_aud_underrun;

    logic                w_in_ready;
    logic                w_accept;
    logic                w_push;
    logic                w_aud_load;
    logic                w_pop;
    logic                w_hs_fall;
    logic                w_full;
    logic                w_empty;
    logic [COLOUR_W-1:0] w_head;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (COLOUR_W)
    ) u_pixel_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_data  (pixel_colour(i_in_data)),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Ready depends only on registered state so timing inputs never reach it.
    always_comb begin
        w_in_ready = 1'b0;
        if (r_run) begin
            case (r_state)
                PIX:     w_in_ready = !w_full;
                AUD:     w_in_ready = !r_hold_valid;
                default: w_in_ready = 1'b0;
            endcase
        end else begin
            w_in_ready = 1'b0;
        end
    end

    assign w_accept   = i_in_valid && w_in_ready;
    assign w_push     = w_accept && (r_state == PIX);
    assign w_aud_load = w_accept && (r_state == AUD);
    assign w_pop      = i_pixel_req && !w_empty;
    assign w_hs_fall  = r_hsync_d && !i_hsync;

    // Stream parser: pixel/line position within the frame.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= PIX;
            r_pix_cnt  <= {PW{1'b0}};
            r_line_cnt <= {LW{1'b0}};
            r_run      <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (w_accept) begin
                case (r_state)
                    PIX: begin
                        if (r_pix_cnt == PW'(LINE_PIXELS - 1)) begin
                            r_pix_cnt <= {PW{1'b0}};
                            r_state   <= AUD;
                        end else begin
                            r_pix_cnt <= r_pix_cnt + PW'(1);
                        end
                    end
                    AUD: begin
                        if (r_line_cnt == LW'(TOTAL_LINES - 1)) begin
                            r_line_cnt <= {LW{1'b0}};
                            r_state    <= PIX;
                        end else begin
                            r_line_cnt <= r_line_cnt + LW'(1);
                            // The line being entered still carries pixels.
                            r_state    <= (r_line_cnt < LW'(ACTIVE_LINES - 1)) ? PIX : AUD;
                        end
                    end
                    default: r_state <= PIX;
                endcase
            end
        end
    end

    // Audio hold and release on the hsync falling edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hold         <= 8'h00;
            r_hold_valid   <= 1'b0;
            r_hsync_d      <= 1'b1;
            r_audio_sample <= AUDIO_MID;
            r_audio_update <= 1'b0;
            r_aud_underrun <= 1'b0;
        end else begin
            r_hsync_d      <= i_hsync;
            r_audio_update <= 1'b0;
            if (w_hs_fall) begin
                if (r_hold_valid) begin
                    r_audio_sample <= r_hold;
                    r_audio_update <= 1'b1;
                end else begin
                    r_aud_underrun <= 1'b1;
                end
            end
            // A byte loaded in the edge cycle wins over the release.
            if (w_aud_load) begin
                r_hold       <= i_in_data;
                r_hold_valid <= 1'b1;
            end else if (w_hs_fall) begin
                r_hold_valid <= 1'b0;
            end
        end
    end

    // Pixel output: head on request, black while blanking or starved.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rgb          <= {COLOUR_W{1'b0}};
            r_pix_underrun <= 1'b0;
        end else if (i_pixel_req) begin
            if (!w_empty) begin
                r_rgb <= w_head;
            end else begin
                r_rgb          <= {COLOUR_W{1'b0}};
                r_pix_underrun <= 1'b1;
            end
        end else begin
            r_rgb <= {COLOUR_W{1'b0}};
        end
    end

    assign o_in_ready     = w_in_ready;
    assign o_rgb          = r_rgb;
    assign o_audio_sample = r_audio_sample;
    assign o_audio_update = r_audio_update;
    assign o_pix_underrun = r_pix_underrun;
    assign o_aud_underrun = r_aud_underrun;

endmodule

// File: tb/tb_av_stream_buffer.sv
// Scoreboard bench for av_stream_buffer with a reduced frame geometry.
// A stream/queue reference model produces per-cycle expectations for a monitor.
module tb_av_stream_buffer;

    localparam int DEPTH  = 4;
    localparam int LINE   = 16;
    localparam int ACTIVE = 4;
    localparam int TOTAL  = 6;
    localparam int FRAME_BYTES = ACTIVE * (LINE + 1) + (TOTAL - ACTIVE);

    typedef struct {
        logic [7:0] data;
        bit         is_aud;
    } item_t;

    typedef struct {
        logic [5:0] rgb;
        logic [7:0] sample;
        logic       upd;
        logic       pu;
        logic       au;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       pixel_req = 1'b0;
    logic       hsync = 1'b1;
    logic [5:0] rgb;
    logic [7:0] audio_sample;
    logic       audio_update;
    logic       pix_underrun;
    logic       aud_underrun;

    av_stream_buffer #(
        .DEPTH        (DEPTH),
        .LINE_PIXELS  (LINE),
        .ACTIVE_LINES (ACTIVE),
        .TOTAL_LINES  (TOTAL)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_in_data      (in_data),
        .i_in_valid     (in_valid),
        .o_in_ready     (in_ready),
        .i_pixel_req    (pixel_req),
        .i_hsync        (hsync),
        .o_rgb          (rgb),
        .o_audio_sample (audio_sample),
        .o_audio_update (audio_update),
        .o_pix_underrun (pix_underrun),
        .o_aud_underrun (aud_underrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    item_t      q_stream[$];
    logic [5:0] pix_q[$];
    exp_t       q_exp[$];
    bit         run_m    = 1'b0;
    bit         hold_v_m = 1'b0;
    bit         hs_prev  = 1'b1;
    bit         pu_m     = 1'b0;
    bit         au_m     = 1'b0;
    logic [7:0] hold_m   = 8'h00;
    logic [7:0] sample_m = 8'h80;
    int         acc_total = 0;
    int         upd_seen  = 0;
    exp_t       mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // One frame of the stream: pixel lines then audio-only lines.
    task automatic gen_frame();
        item_t it;
        for (int l = 0; l < TOTAL; l++) begin
            if (l < ACTIVE) begin
                for (int p = 0; p < LINE; p++) begin
                    it.data   = 8'($urandom);
                    it.is_aud = 1'b0;
                    q_stream.push_back(it);
                end
            end
            it.data   = 8'($urandom);
            it.is_aud = 1'b1;
            q_stream.push_back(it);
        end
    endtask

    task automatic prep_stream();
        q_stream.delete();
        gen_frame();
    endtask

    // Drive one cycle and advance the reference model across the coming edge.
    task automatic step(input logic r, input logic v, input logic preq, input logic hs);
        exp_t  e;
        item_t it;
        logic  ir;
        logic  acc;
        @(negedge clk);
        if (q_stream.size() == 0) gen_frame();
        rst       = r;
        in_valid  = v;
        pixel_req = preq;
        hsync     = hs;
        in_data   = v ? q_stream[0].data : 8'($urandom);
        ir = run_m && (q_stream[0].is_aud ? !hold_v_m : (pix_q.size() < DEPTH));
        chk("in_ready", in_ready, ir);
        acc   = v && ir;
        e.upd = 1'b0;
        e.rgb = 6'h00;
        if (r) begin
            run_m    = 1'b0;
            hold_v_m = 1'b0;
            hs_prev  = 1'b1;
            pu_m     = 1'b0;
            au_m     = 1'b0;
            sample_m = 8'h80;
            acc_total = 0;
            pix_q.delete();
            q_stream.delete();
        end else begin
            run_m = 1'b1;
            if (preq) begin
                if (pix_q.size() > 0) e.rgb = pix_q.pop_front();
                else pu_m = 1'b1;
            end
            if (hs_prev && !hs) begin
                if (hold_v_m) begin
                    sample_m = hold_m;
                    e.upd    = 1'b1;
                    hold_v_m = 1'b0;
                end else begin
                    au_m = 1'b1;
                end
            end
            hs_prev = hs;
            if (acc) begin
                it = q_stream.pop_front();
                acc_total++;
                if (it.is_aud) begin
                    hold_m   = it.data;
                    hold_v_m = 1'b1;
                end else begin
                    pix_q.push_back(it.data[5:0]);
                end
            end
        end
        e.sample = sample_m;
        e.pu     = pu_m;
        e.au     = au_m;
        q_exp.push_back(e);
        @(posedge clk);
    endtask

    // Monitor: compare registered outputs just after every edge.
    always @(posedge clk) begin
        #1;
        if (q_exp.size() > 0) begin
            mon_e = q_exp.pop_front();
            chk("rgb", rgb, mon_e.rgb);
            chk("audio_sample", audio_sample, mon_e.sample);
            chk("audio_update", audio_update, mon_e.upd);
            chk("pix_underrun", pix_underrun, mon_e.pu);
            chk("aud_underrun", aud_underrun, mon_e.au);
            if (audio_update === 1'b1) upd_seen++;
        end
    end

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
    endtask

    initial begin
        int  upd_base;
        bit  hs_last;
        bit  hs_v;

        // Reset with valid asserted, then ready on the first free cycle.
        do_reset(3);
        #2;
        chk("reset_rgb", rgb, 6'h00);
        chk("reset_sample", audio_sample, 8'h80);
        chk("reset_ready", in_ready, 1'b0);
        prep_stream();
        q_stream[0].data = 8'h3F;
        q_stream[1].data = 8'h15;
        q_stream[2].data = 8'h2A;
        q_stream[3].data = 8'h01;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        #2;
        chk("ready_after_reset", in_ready, 1'b1);

        // Fill without pops, then drain four entries.
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
        #2;
        chk("fill_ready", in_ready, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        #2;
        chk("fill_rgb0", rgb, 6'h3F);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1);
        #2;
        chk("fill_rgb3", rgb, 6'h01);
        chk("fill_no_underrun", pix_underrun, 1'b0);

        // Underrun on an empty pop, sticky across a refill.
        step(1'b0, 1'b0, 1'b1, 1'b1);
        #2;
        chk("underrun_set", pix_underrun, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
        #2;
        chk("underrun_sticky", pix_underrun, 1'b1);

        // One line plus its audio byte, released at the next hsync fall.
        do_reset(2);
        prep_stream();
        q_stream[LINE].data = 8'hC4;
        for (int i = 0; i < 200 && acc_total < LINE + 1; i++)
            step(1'b0, 1'b1, pix_q.size() > 0, 1'b1);
        chk("line_accepted", acc_total, LINE + 1);
        upd_base = upd_seen;
        step(1'b0, 1'b0, pix_q.size() > 0, 1'b1);
        step(1'b0, 1'b0, pix_q.size() > 0, 1'b0);
        #2;
        chk("line_sample", audio_sample, 8'hC4);
        step(1'b0, 1'b0, pix_q.size() > 0, 1'b0);
        step(1'b0, 1'b0, pix_q.size() > 0, 1'b1);
        #2;
        chk("line_one_pulse", upd_seen - upd_base, 1);

        // Full frame with hsync falls only while audio is held.
        do_reset(2);
        prep_stream();
        upd_base = upd_seen;
        hs_last  = 1'b1;
        for (int i = 0; i < 3000 && (acc_total < FRAME_BYTES || hold_v_m); i++) begin
            hs_v = (hs_last && hold_v_m) ? 1'b0 : 1'b1;
            step(1'b0, acc_total < FRAME_BYTES, pix_q.size() > 0, hs_v);
            hs_last = hs_v;
        end
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, pix_q.size() > 0, 1'b1);
        #2;
        chk("frame_updates", upd_seen - upd_base, TOTAL);
        chk("frame_pix_unr", pix_underrun, 1'b0);
        chk("frame_aud_unr", aud_underrun, 1'b0);
        chk("frame_wrap_ready", in_ready, 1'b1);

        // Audio byte offered while the previous one is still held at the edge.
        do_reset(2);
        prep_stream();
        q_stream[LINE].data = 8'h10;
        q_stream[2 * LINE + 1].data = 8'h20;
        for (int i = 0; i < 200 && !(q_stream[0].is_aud && q_stream[0].data == 8'h20 && hold_v_m); i++)
            step(1'b0, 1'b1, pix_q.size() > 0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        #2;
        chk("simul_old_out", audio_sample, 8'h10);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        chk("simul_new_out", audio_sample, 8'h20);

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset(1);
            end else begin
                step(1'b0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                     $urandom_range(0, 3) != 0);
            end
        end

        step(1'b0, 1'b0, 1'b0, 1'b1);
        #2;
        chk("scoreboard_drained", q_exp.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
